// File: rtl/minion_bus_pkg.sv
// Shared types and defaults for the minion bus decoder.
// The FSM state type, default parameter values and the error read-data value.
package minion_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int DEF_NUM_SLAVES = 16;
  localparam int DEF_SEL_LSB    = 20;
  localparam int DEF_SEL_W      = 4;
  localparam int DEF_ADDR_W     = 20;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_TIMEOUT    = 255;

  // Widest data bus supported; narrower buses take the low slice.
  localparam int MAX_DATA_W = 1024;
  localparam logic [MAX_DATA_W-1:0] ERR_RDATA = '0;

endpackage

// File: rtl/minion_bus_wdog.sv
// BUSY-phase watchdog: cleared on entry to BUSY, counts stalled cycles.
// expire flags the last permitted stall cycle; it is constant 0 when TIMEOUT is 0.
module minion_bus_wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= cnt + CNT_W'(1);
  end

  generate
    if (TIMEOUT == 0) begin : g_off
      logic cnt_unused;
      assign cnt_unused = ^cnt;
      assign expire     = 1'b0;
    end else begin : g_on
      // Abort at the edge where the count would reach TIMEOUT.
      localparam logic [CNT_W-1:0] LIM = CNT_W'(TIMEOUT - 1);
      assign expire = (cnt == LIM);
    end
  endgenerate

endmodule

// File: rtl/minion_bus_decoder.sv
// Single-master decoder from the core LSU port to NUM_SLAVES minion bus slots,
// with registered one-hot chip enables, wait-state support, watchdog and error response.
module minion_bus_decoder
  import minion_bus_pkg::*;
#(
  parameter int NUM_SLAVES = DEF_NUM_SLAVES,
  parameter int SEL_LSB    = DEF_SEL_LSB,
  parameter int SEL_W      = DEF_SEL_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         core_lsu_req,
  output logic                         core_lsu_gnt,
  input  logic [31:0]                  core_lsu_addr,
  input  logic                         core_lsu_we,
  input  logic [DATA_W/8-1:0]          core_lsu_be,
  input  logic [DATA_W-1:0]            core_lsu_wdata,
  output logic                         core_lsu_rvalid,
  output logic [DATA_W-1:0]            core_lsu_rdata,
  output logic                         core_lsu_err,
  output logic [ADDR_W-1:0]            bus_addr,
  output logic [DATA_W-1:0]            bus_wdata,
  output logic [DATA_W/8-1:0]          bus_be,
  output logic [NUM_SLAVES-1:0]        bus_ce,
  output logic [NUM_SLAVES-1:0]        bus_we,
  input  logic [NUM_SLAVES-1:0]        bus_rdy,
  input  logic [NUM_SLAVES*DATA_W-1:0] bus_rdata
);

  generate
    if (NUM_SLAVES < 1 || NUM_SLAVES > 2**SEL_W) begin : g_bad_slaves
      $error("minion_bus_decoder: NUM_SLAVES must be 1..2**SEL_W");
    end
    if (DATA_W % 8 != 0 || DATA_W > MAX_DATA_W) begin : g_bad_data
      $error("minion_bus_decoder: DATA_W must be a multiple of 8 within MAX_DATA_W");
    end
    if (ADDR_W > 32 || SEL_LSB + SEL_W > 32) begin : g_bad_addr
      $error("minion_bus_decoder: address fields exceed 32 bits");
    end
  endgenerate

  state_e                state_q, state_d;
  logic [SEL_W-1:0]      sel_in, sel_q;
  logic                  mapped, we_q;
  logic                  ld, rsp_ld, rsp_err_d;
  logic                  rdy_hit, wd_clr, wd_en, wd_expire;
  logic [DATA_W-1:0]     sel_rdata, rsp_data_d;
  logic [NUM_SLAVES-1:0] ce_d, we_d, sel_oh;

  // Only the select field and the forwarded low bits matter; the rest is don't-care.
  logic addr_unused;
  assign addr_unused = ^core_lsu_addr;

  assign sel_in          = core_lsu_addr[SEL_LSB +: SEL_W];
  assign mapped          = 32'(sel_in) < 32'(NUM_SLAVES);
  assign sel_oh          = NUM_SLAVES'(1) << sel_in;
  assign wd_en           = (state_q == BUSY) && !rdy_hit;
  assign core_lsu_rvalid = (state_q == RESP);

  // Only the latched slot's ready/data are observed; other slots are ignored.
  always_comb begin
    rdy_hit   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q == SEL_W'(i)) begin
        rdy_hit   = bus_rdy[i];
        sel_rdata = bus_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    core_lsu_gnt = 1'b0;
    ld           = 1'b0;
    wd_clr       = 1'b0;
    ce_d         = bus_ce;
    we_d         = bus_we;
    rsp_ld       = 1'b0;
    rsp_err_d    = 1'b0;
    rsp_data_d   = ERR_RDATA[DATA_W-1:0];
    unique case (state_q)
      IDLE: begin
        core_lsu_gnt = core_lsu_req;
        if (core_lsu_req) begin
          ld = 1'b1;
          if (mapped) begin
            state_d = BUSY;
            wd_clr  = 1'b1;
            ce_d    = sel_oh;
            we_d    = core_lsu_we ? sel_oh : '0;
          end else begin
            state_d   = RESP;
            rsp_ld    = 1'b1;
            rsp_err_d = 1'b1;
          end
        end
      end
      BUSY: begin
        if (rdy_hit) begin
          state_d    = RESP;
          rsp_ld     = 1'b1;
          rsp_data_d = we_q ? '0 : sel_rdata;
          ce_d       = '0;
          we_d       = '0;
        end else if (wd_expire) begin
          state_d   = RESP;
          rsp_ld    = 1'b1;
          rsp_err_d = 1'b1;
          ce_d      = '0;
          we_d      = '0;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      sel_q          <= '0;
      we_q           <= 1'b0;
      bus_addr       <= '0;
      bus_wdata      <= '0;
      bus_be         <= '0;
      bus_ce         <= '0;
      bus_we         <= '0;
      core_lsu_rdata <= '0;
      core_lsu_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      bus_ce  <= ce_d;
      bus_we  <= we_d;
      if (ld) begin
        sel_q     <= sel_in;
        we_q      <= core_lsu_we;
        bus_addr  <= core_lsu_addr[ADDR_W-1:0];
        bus_wdata <= core_lsu_wdata;
        bus_be    <= core_lsu_be;
      end
      // Response data and flag persist until the next response overwrites them.
      if (rsp_ld) begin
        core_lsu_rdata <= rsp_data_d;
        core_lsu_err   <= rsp_err_d;
      end
    end
  end

  minion_bus_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (wd_clr),
    .en     (wd_en),
    .expire (wd_expire)
  );

endmodule

// File: tb/tb_minion_bus_decoder.sv
// Randomized scoreboard bench for minion_bus_decoder (8 slots, TIMEOUT=16).
// Driver pushes model responses; a monitor pops them on rvalid; a slave model checks bus outputs.
module tb_minion_bus_decoder;

  localparam int NS = 8;
  localparam int DW = 32;
  localparam int AW = 20;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              core_lsu_req, core_lsu_gnt, core_lsu_we;
  logic [31:0]       core_lsu_addr;
  logic [DW/8-1:0]   core_lsu_be;
  logic [DW-1:0]     core_lsu_wdata, core_lsu_rdata;
  logic              core_lsu_rvalid, core_lsu_err;
  logic [AW-1:0]     bus_addr;
  logic [DW-1:0]     bus_wdata;
  logic [DW/8-1:0]   bus_be;
  logic [NS-1:0]     bus_ce, bus_we, bus_rdy;
  logic [NS*DW-1:0]  bus_rdata;

  always #5 clk = ~clk;

  minion_bus_decoder #(
    .NUM_SLAVES(NS), .SEL_LSB(20), .SEL_W(4), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .core_lsu_req(core_lsu_req), .core_lsu_gnt(core_lsu_gnt),
    .core_lsu_addr(core_lsu_addr), .core_lsu_we(core_lsu_we),
    .core_lsu_be(core_lsu_be), .core_lsu_wdata(core_lsu_wdata),
    .core_lsu_rvalid(core_lsu_rvalid), .core_lsu_rdata(core_lsu_rdata),
    .core_lsu_err(core_lsu_err),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ce(bus_ce), .bus_we(bus_we), .bus_rdy(bus_rdy), .bus_rdata(bus_rdata)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          ce_cyc;
    int          t0;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0, n_bad = 0, cyc = 0;
  bit          outstanding = 0;
  int          tgt = 0, cur_wt = 0, ce_cnt = 0;
  logic        cur_we = 1'b0;
  logic [31:0] cur_addr = '0, cur_wdata = '0, cur_data = '0;
  logic [3:0]  cur_be = '0;
  logic [31:0] slot_data[NS];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural response: slot decode, wait states vs watchdog, read/write data.
  function automatic exp_t model(input logic [31:0] addr, input logic we, input int wt,
                                 input logic [31:0] sd);
    exp_t e;
    int   sel;
    sel = int'(addr[23:20]);
    e.t0 = 0;
    if (sel >= NS) begin
      e.rdata = '0; e.err = 1'b1; e.lat = 1; e.ce_cyc = 0;
    end else if (wt >= TO) begin
      e.rdata = '0; e.err = 1'b1; e.lat = TO + 1; e.ce_cyc = TO;
    end else begin
      e.rdata = we ? 32'h0 : sd; e.err = 1'b0; e.lat = 2 + wt; e.ce_cyc = wt + 1;
    end
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: ready after cur_wt wait states on the target; noise everywhere else.
  always @(negedge clk) begin : slave
    logic [NS-1:0]    r, oh;
    logic [NS*DW-1:0] d;
    if (bus_ce[tgt]) ce_cnt++;
    if (bus_ce != '0 || bus_we != '0) begin
      oh = '0;
      oh[tgt] = 1'b1;
      chk("bus_ce", bus_ce, oh);
      chk("bus_we", bus_we, cur_we ? oh : '0);
      chk("bus_addr", bus_addr, cur_addr[AW-1:0]);
      chk("bus_wdata", bus_wdata, cur_wdata);
      chk("bus_be", bus_be, cur_be);
    end
    for (int i = 0; i < NS; i++) begin
      r[i] = 1'($urandom);
      d[i*DW +: DW] = $urandom;
    end
    r[tgt] = bus_ce[tgt] ? (ce_cnt > cur_wt) : 1'($urandom);
    d[tgt*DW +: DW] = cur_data;
    bus_rdy   = r;
    bus_rdata = d;
  end

  // Monitor: pop and compare on every rvalid, then check the one-cycle pulse and hold.
  initial begin : monitor
    exp_t        e;
    logic [31:0] hd;
    logic        he;
    forever begin
      @(negedge clk);
      if (!rst && core_lsu_rvalid) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_rvalid: got rvalid=1 expected none (t=%0t)", $time);
        end else begin
          e = q.pop_front();
          chk("rdata", core_lsu_rdata, e.rdata);
          chk("err", core_lsu_err, e.err);
          chk("latency", cyc - e.t0, e.lat);
          chk("ce_cycles", ce_cnt, e.ce_cyc);
        end
        hd = core_lsu_rdata;
        he = core_lsu_err;
        @(posedge clk);
        outstanding = 0;
        @(negedge clk);
        if (!rst) begin
          chk("rvalid_pulse", core_lsu_rvalid, 1'b0);
          chk("rdata_hold", core_lsu_rdata, hd);
          chk("err_hold", core_lsu_err, he);
        end
      end
    end
  end

  task automatic xfer(input logic [31:0] addr, input logic we, input logic [3:0] be,
                      input logic [31:0] wdata, input int wt, input bit hold, input bit rsp);
    int   n = 0;
    int   sel;
    exp_t e;
    @(negedge clk);
    core_lsu_req = 1'b1; core_lsu_addr = addr; core_lsu_we = we;
    core_lsu_be = be; core_lsu_wdata = wdata;
    forever begin
      #1;
      chk("gnt", core_lsu_gnt, !outstanding);
      if (core_lsu_gnt) break;
      if (++n > 60) begin
        n_cmp++; n_bad++;
        $display("FAIL gnt_timeout: got no grant expected grant within 60 cycles");
        core_lsu_req = 1'b0;
        return;
      end
      @(negedge clk);
    end
    sel = int'(addr[23:20]);
    tgt = (sel < NS) ? sel : 0;
    cur_addr = addr; cur_we = we; cur_be = be; cur_wdata = wdata;
    cur_wt = wt; cur_data = slot_data[tgt]; ce_cnt = 0;
    if (rsp) begin
      e = model(addr, we, wt, slot_data[tgt]);
      e.t0 = cyc;
      q.push_back(e);
    end
    outstanding = 1;
    @(posedge clk);
    if (!hold) begin
      #1;
      core_lsu_req = 1'b0;
    end
  endtask

  initial begin : global_bound
    #400000;
    $display("FAIL global_timeout: got no completion expected finish");
    $fatal(1, "simulation time bound exceeded");
  end

  initial begin : stim
    int wts[8] = '{0, 1, 2, 3, 5, 15, 16, 40};
    int n;
    logic [3:0] s;
    bit h;
    rst = 1'b1;
    core_lsu_req = 1'b0; core_lsu_addr = '0; core_lsu_we = 1'b0;
    core_lsu_be = '0; core_lsu_wdata = '0;
    bus_rdy = '0; bus_rdata = '0;
    for (int i = 0; i < NS; i++) slot_data[i] = $urandom;
    #3;
    chk("rst_rvalid", core_lsu_rvalid, 1'b0);
    chk("rst_gnt", core_lsu_gnt, 1'b0);
    chk("rst_ce", bus_ce, '0);
    chk("rst_rdata", core_lsu_rdata, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    slot_data[3] = 32'hA5A5_0003;
    xfer(32'h0030_0010, 1'b0, 4'hF, 32'h0, 0, 0, 1);
    xfer(32'h0000_0ABC, 1'b1, 4'b0011, 32'h1234_5678, 3, 0, 1);
    xfer(32'h00A0_0000, 1'b0, 4'hF, 32'h0, 0, 0, 1);
    xfer(32'h0050_0040, 1'b0, 4'hF, 32'h0, 1000, 0, 1);
    xfer(32'h0060_0004, 1'b0, 4'hF, 32'h0, 15, 0, 1);
    xfer(32'h0060_0008, 1'b1, 4'hC, 32'hCAFE_F00D, 16, 0, 1);

    // Abort an access with reset while the slave is stalling.
    xfer(32'h0010_0ABC, 1'b1, 4'h5, 32'hDEAD_BEEF, 1000, 0, 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_ce", bus_ce, '0);
    chk("arst_we", bus_we, '0);
    chk("arst_addr", bus_addr, '0);
    chk("arst_wdata", bus_wdata, '0);
    chk("arst_be", bus_be, '0);
    chk("arst_rvalid", core_lsu_rvalid, 1'b0);
    q.delete();
    outstanding = 0;
    cur_wt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    slot_data[1] = 32'h0101_5A5A;
    xfer(32'h0010_0020, 1'b0, 4'hF, 32'h0, 2, 0, 1);

    slot_data[2] = 32'h2222_0002;
    slot_data[4] = 32'h4444_0004;
    xfer(32'h0020_0100, 1'b0, 4'hF, 32'h0, 1, 1, 1);
    xfer(32'h0040_0200, 1'b0, 4'hF, 32'h0, 0, 0, 1);

    for (int k = 0; k < 40; k++) begin
      s = 4'($urandom_range(0, 15));
      if (int'(s) < NS) slot_data[s[2:0]] = $urandom;
      h = ($urandom_range(0, 3) == 0) && (k != 39);
      xfer({8'($urandom), s, 20'($urandom)}, 1'($urandom), 4'($urandom), $urandom,
           wts[$urandom_range(0, 7)], h, 1);
      if (!h) repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: got %0d pending responses expected 0", q.size());
    end
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/minion_bus_decoder.md
Name: minion_bus_decoder

Overview:
Parametrised single-master bus decoder between the core LSU data port and NUM_SLAVES peripheral slots on the minion bus. A slot is selected by an address field, and a registered chip-enable/write-enable is driven to that slot only. The block waits for a per-slot ready, then returns read data to the core with a single-cycle rvalid pulse. It adds slave wait states, a timeout watchdog and an error response for unmapped slots and timed-out accesses.

Parameters:
NUM_SLAVES, 16, number of peripheral slots (1..2**SEL_W).
SEL_LSB, 20, lowest address bit of the slot-select field.
SEL_W, 4, width of the slot-select field.
ADDR_W, 20, width of the address forwarded to peripherals.
DATA_W, 32, data width (multiple of 8).
TIMEOUT, 255, maximum BUSY cycles before abort; 0 disables the watchdog.

Ports:
clk  in  1  system clock.
rst  in  1  reset; one clock; reset is asynchronous and active-high.
core_lsu_req  in  1  core access request.
core_lsu_gnt  out  1  grant; combinational, equals req while in IDLE.
core_lsu_addr  in  32  byte address.
core_lsu_we  in  1  1 = write.
core_lsu_be  in  DATA_W/8  byte enables.
core_lsu_wdata  in  DATA_W  write data.
core_lsu_rvalid  out  1  one-cycle response pulse.
core_lsu_rdata  out  DATA_W  read data, valid with rvalid.
core_lsu_err  out  1  error flag, valid with rvalid.
bus_addr  out  ADDR_W  latched addr[ADDR_W-1:0].
bus_wdata  out  DATA_W  latched write data.
bus_be  out  DATA_W/8  latched byte enables.
bus_ce  out  NUM_SLAVES  one-hot chip enable.
bus_we  out  NUM_SLAVES  one-hot write enable (subset of bus_ce).
bus_rdy  in  NUM_SLAVES  per-slot ready.
bus_rdata  in  NUM_SLAVES*DATA_W  slot i read data at [i*DATA_W +: DATA_W].

Behaviour:
- Reset: all registered outputs are 0, state is IDLE, and the watchdog is 0. Reset asserted mid-access abandons the access; no rvalid is issued for it.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - gnt = req.
  - On req, latch addr, wdata, be and we, and compute sel = addr[SEL_LSB +: SEL_W].
  - If sel >= NUM_SLAVES, go to RESP with err=1 and rdata=0; no bus_ce is asserted.
  - Otherwise go to BUSY. bus_ce[sel]=1 and bus_we[sel]=we are registered, so both are visible on the next cycle.
- BUSY:
  - bus_ce[sel], bus_we[sel], bus_addr, bus_wdata and bus_be are held stable.
  - bus_rdy[sel] sampled high, including in the first BUSY cycle (zero-wait slave):
    - On a read, capture bus_rdata[sel]; on a write, capture 0.
    - Set err=0, clear ce/we at the same edge, and go to RESP.
  - Watchdog increments each BUSY cycle without rdy. If TIMEOUT != 0 and the count reaches TIMEOUT, clear ce/we, set err=1 and rdata=0, and go to RESP.
  - bus_rdy on non-selected slots, or outside BUSY, is ignored.
- RESP: rvalid=1 for exactly one cycle with rdata and err; gnt=0; next state is IDLE. rdata and err hold their values until the next response.
- Latency (cycle of gnt = 0):
  - zero-wait slave: ce at cycle 1, rvalid at cycle 2;
  - N wait states: rvalid at cycle 2+N;
  - unmapped slot: rvalid at cycle 1.
- Throughput: at most one outstanding access; responses are returned in request order.
- Watchdog width is clog2(TIMEOUT+1), minimum 1, and it resets to 0 on entry to BUSY.
- Elaboration error if NUM_SLAVES > 2**SEL_W or DATA_W%8 != 0.

Decomposition:
- Package minion_bus_pkg holds:
  - the state enum (IDLE, BUSY, RESP);
  - default parameter constants;
  - the error read-data constant (all zeros).
- One sub-module, minion_bus_wdog: clear/enable/expire counter parametrised by TIMEOUT, with expire tied to 0 when TIMEOUT=0.

Test Plan:
1. Read from slot 3, zero-wait: addr 0x0030_0010, bus_rdy[3]=1, bus_rdata slot3=0xA5A5_0003 -> gnt at cycle 0; bus_ce=0x0008 and bus_addr=0x00010 at cycle 1; rvalid at cycle 2 with rdata 0xA5A5_0003, err 0.
2. Write to slot 0, 3 wait states: be 4'b0011, wdata 0x1234_5678 -> ce[0] and we[0] high for 4 cycles with bus_wdata and bus_be stable; rvalid one cycle after rdy, rdata 0, err 0.
3. Unmapped slot, NUM_SLAVES=8: addr 0x00A0_0000 -> bus_ce stays 0; rvalid at cycle 1 with err 1, rdata 0.
4. Timeout, TIMEOUT=16: slot 5 never asserts rdy -> ce[5] high for 16 cycles then low; rvalid with err 1, rdata 0.
5. Reset asserted in BUSY -> all outputs go to 0 asynchronously and no rvalid is issued; a following read of slot 1 completes normally.
6. req held high for two reads (slots 2 then 4), with bus_rdy[7] toggling throughout -> gnt only in IDLE; two rvalids in order with the correct data; slot 7 activity ignored.
